regfile_write_arbiter: RTL and testbench

REGFILE_WRITE_ARBITER -- requirements
Module: regfile_write_arbiter

---
 rtl/regfile_write_arbiter_pkg.sv | 16 +
 rtl/regfile_write_arbiter_if.sv | 34 +++
 rtl/regfile_write_arbiter_rr_arbiter2.sv | 38 +++
 rtl/regfile_write_arbiter.sv | 102 ++++++++++
 tb/tb_regfile_write_arbiter.sv | 226 ++++++++++++++++++++++
 5 files changed

// File: rtl/regfile_write_arbiter_pkg.sv
// Shared types and constants for the register-file write arbiter.
// Requester IDs double as the select encoding on the write port.
package regfile_write_arbiter_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_WRITE = 2'd1,
    ST_HOLD  = 2'd2
  } arbState_t;

  localparam logic REQ_A = 1'b1;
  localparam logic REQ_B = 1'b0;

  localparam int COUNT_W = 8;

endpackage

// File: rtl/regfile_write_arbiter_if.sv
// Bus between the two writeback requesters, the hold control and the register file.
interface regfile_write_arbiter_if #(
  parameter int DATA_W = 16,
  parameter int ADDR_W = 3
);

  logic                 a_valid;
  logic [ADDR_W-1:0]    a_dest;
  logic [DATA_W-1:0]    a_data;
  logic                 a_ready;
  logic                 b_valid;
  logic [ADDR_W-1:0]    b_dest;
  logic [DATA_W-1:0]    b_data;
  logic                 b_ready;
  logic                 wr_hold;
  logic                 regWrite;
  logic [ADDR_W-1:0]    rd1;
  logic [ADDR_W-1:0]    rd2;
  logic                 select;
  logic [DATA_W-1:0]    writeData;
  logic [2**ADDR_W-1:0] pending_mask;
  logic [7:0]           wr_count;

  modport slave (
    input  a_valid, a_dest, a_data, b_valid, b_dest, b_data, wr_hold,
    output a_ready, b_ready, regWrite, rd1, rd2, select, writeData, pending_mask, wr_count
  );

  modport master (
    output a_valid, a_dest, a_data, b_valid, b_dest, b_data, wr_hold,
    input  a_ready, b_ready, regWrite, rd1, rd2, select, writeData, pending_mask, wr_count
  );

endinterface

// File: rtl/regfile_write_arbiter_rr_arbiter2.sv
// Two-requester round-robin grant; the pointer remembers the last winner
// and only moves when a grant is actually issued.
module rr_arbiter2
  import regfile_write_arbiter_pkg::*;
(
  input  logic clk,
  input  logic reset,
  input  logic enable,
  input  logic reqA,
  input  logic reqB,
  output logic grantA,
  output logic grantB
);

  logic lastGrant;

  always_comb begin
    grantA = 1'b0;
    grantB = 1'b0;
    if (enable) begin
      if (reqA && reqB) begin
        if (lastGrant == REQ_A) grantB = 1'b1;
        else                    grantA = 1'b1;
      end else begin
        grantA = reqA;
        grantB = reqB;
      end
    end
  end

  // Starting from "B won last" gives A priority out of reset.
  always_ff @(posedge clk or posedge reset) begin
    if (reset)       lastGrant <= REQ_B;
    else if (grantA) lastGrant <= REQ_A;
    else if (grantB) lastGrant <= REQ_B;
  end

endmodule

// File: rtl/regfile_write_arbiter.sv
// Arbitrates ALU and load writebacks onto a single register-file write port
// with one cycle of latency; an external hold blocks new grants.
//
// state    | meaning
// ST_IDLE  | no write presented; grants allowed
// ST_WRITE | write presented to the register file this cycle
// ST_HOLD  | external hold seen; no grants until it drops
module regfile_write_arbiter
  import regfile_write_arbiter_pkg::*;
#(
  parameter int DATA_W = 16,
  parameter int ADDR_W = 3
) (
  input logic                    clk,
  input logic                    reset,
  regfile_write_arbiter_if.slave bus
);

  arbState_t            state;
  arbState_t            nextState;
  logic                 grantA;
  logic                 grantB;
  logic                 accept;
  logic                 arbEnable;
  logic                 selectQ;
  logic [ADDR_W-1:0]    rd1Q;
  logic [ADDR_W-1:0]    rd2Q;
  logic [DATA_W-1:0]    dataQ;
  logic [COUNT_W-1:0]   countQ;
  logic [ADDR_W-1:0]    wrAddr;
  logic [2**ADDR_W-1:0] pendingMask;

  assign arbEnable = !reset && !bus.wr_hold && (state != ST_HOLD);
  assign accept    = grantA || grantB;

  rr_arbiter2 u_rr (
    .clk    (clk),
    .reset  (reset),
    .enable (arbEnable),
    .reqA   (bus.a_valid),
    .reqB   (bus.b_valid),
    .grantA (grantA),
    .grantB (grantB)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= ST_IDLE;
    else       state <= nextState;
  end

  always_comb begin
    nextState = state;
    case (state)
      ST_IDLE, ST_WRITE: begin
        if (bus.wr_hold)  nextState = ST_HOLD;
        else if (accept)  nextState = ST_WRITE;
        else              nextState = ST_IDLE;
      end
      ST_HOLD: begin
        if (!bus.wr_hold) nextState = ST_IDLE;
      end
      default: nextState = ST_IDLE;
    endcase
  end

  // Only the winning side's address register moves; the other keeps its last value.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      selectQ <= REQ_B;
      rd1Q    <= '0;
      rd2Q    <= '0;
      dataQ   <= '0;
      countQ  <= '0;
    end else begin
      if (accept) begin
        selectQ <= grantA ? REQ_A : REQ_B;
        if (grantA) rd1Q <= bus.a_dest;
        else        rd2Q <= bus.b_dest;
        dataQ   <= grantA ? bus.a_data : bus.b_data;
      end
      if (state == ST_WRITE) countQ <= countQ + 8'd1;
    end
  end

  assign wrAddr = (selectQ == REQ_A) ? rd1Q : rd2Q;

  always_comb begin
    pendingMask         = '0;
    pendingMask[wrAddr] = (state == ST_WRITE);
  end

  assign bus.a_ready      = grantA;
  assign bus.b_ready      = grantB;
  assign bus.regWrite     = (state == ST_WRITE);
  assign bus.select       = selectQ;
  assign bus.rd1          = rd1Q;
  assign bus.rd2          = rd2Q;
  assign bus.writeData    = dataQ;
  assign bus.pending_mask = pendingMask;
  assign bus.wr_count     = countQ;

endmodule

// File: tb/tb_regfile_write_arbiter.sv
// Scoreboard bench: a reference grant model predicts each acceptance at the
// falling edge and queues the write expected on the port one cycle later.
module tb_regfile_write_arbiter;
  import regfile_write_arbiter_pkg::*;

  localparam int DATA_W = 16;
  localparam int ADDR_W = 3;

  typedef struct {
    logic              sel;
    logic [ADDR_W-1:0] dest;
    logic [DATA_W-1:0] data;
  } expWrite_t;

  logic clk = 1'b0;
  logic reset = 1'b1;
  int   checks = 0;
  int   failures = 0;

  expWrite_t         expQ[$];
  logic              modelHold = 1'b0;
  logic              modelLast = REQ_B;
  logic [7:0]        modelCount = '0;
  logic              modelSel = REQ_B;
  logic [ADDR_W-1:0] modelRd1 = '0;
  logic [ADDR_W-1:0] modelRd2 = '0;
  logic [DATA_W-1:0] modelData = '0;
  logic [DATA_W-1:0] shadowRegs [2**ADDR_W];

  regfile_write_arbiter_if #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) bus ();

  regfile_write_arbiter #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  always #5 clk = ~clk;

  task automatic checkEq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=0x%0h exp=0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Register file rebuilt from what the DUT actually commits.
  always @(posedge clk) begin
    if (!reset && bus.regWrite)
      shadowRegs[bus.select ? bus.rd1 : bus.rd2] <= bus.writeData;
  end

  always @(negedge clk) begin
    expWrite_t e;
    logic expA, expB;
    if (reset) begin
      expQ.delete();
      modelHold  = 1'b0;
      modelLast  = REQ_B;
      modelCount = '0;
      modelSel   = REQ_B;
      modelRd1   = '0;
      modelRd2   = '0;
      modelData  = '0;
      checkEq("rst_regWrite", bus.regWrite, 0);
      checkEq("rst_a_ready", bus.a_ready, 0);
      checkEq("rst_b_ready", bus.b_ready, 0);
      checkEq("rst_wr_count", bus.wr_count, 0);
      checkEq("rst_pending", bus.pending_mask, 0);
    end else begin
      checkEq("wr_count", bus.wr_count, modelCount);
      if (expQ.size() > 0) begin
        e = expQ.pop_front();
        modelSel  = e.sel;
        modelData = e.data;
        if (e.sel == REQ_A) modelRd1 = e.dest;
        else                modelRd2 = e.dest;
        checkEq("regWrite", bus.regWrite, 1);
        checkEq("pending_mask", bus.pending_mask, 32'(1) << e.dest);
        modelCount = modelCount + 8'd1;
      end else begin
        checkEq("regWrite_idle", bus.regWrite, 0);
        checkEq("pending_idle", bus.pending_mask, 0);
      end
      checkEq("select", bus.select, modelSel);
      checkEq("rd1", bus.rd1, modelRd1);
      checkEq("rd2", bus.rd2, modelRd2);
      checkEq("writeData", bus.writeData, modelData);

      expA = 1'b0;
      expB = 1'b0;
      if (!bus.wr_hold && !modelHold) begin
        if (bus.a_valid && bus.b_valid) begin
          if (modelLast == REQ_A) expB = 1'b1;
          else                    expA = 1'b1;
        end else begin
          expA = bus.a_valid;
          expB = bus.b_valid;
        end
      end
      checkEq("a_ready", bus.a_ready, expA);
      checkEq("b_ready", bus.b_ready, expB);
      if (expA) begin
        expQ.push_back('{sel: REQ_A, dest: bus.a_dest, data: bus.a_data});
        modelLast = REQ_A;
      end else if (expB) begin
        expQ.push_back('{sel: REQ_B, dest: bus.b_dest, data: bus.b_data});
        modelLast = REQ_B;
      end
      modelHold = bus.wr_hold;
    end
  end

  task automatic doReset();
    reset = 1'b1;
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
  endtask

  initial begin
    bus.a_valid = 1'b0; bus.a_dest = '0; bus.a_data = '0;
    bus.b_valid = 1'b0; bus.b_dest = '0; bus.b_data = '0;
    bus.wr_hold = 1'b0;
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;

    // single A write
    @(posedge clk); #1;
    bus.a_valid = 1'b1; bus.a_dest = 3'd3; bus.a_data = 16'd3;
    #1 checkEq("single_a_ready", bus.a_ready, 1);
    @(posedge clk); #1 bus.a_valid = 1'b0;
    #2;
    checkEq("single_regWrite", bus.regWrite, 1);
    checkEq("single_select", bus.select, 1);
    checkEq("single_rd1", bus.rd1, 3);
    checkEq("single_data", bus.writeData, 16'd3);
    checkEq("single_mask", bus.pending_mask, 8'h08);
    @(posedge clk); #3 checkEq("single_count", bus.wr_count, 1);

    // contention after reset: A,B,A,B
    doReset();
    @(posedge clk); #1;
    bus.a_valid = 1'b1; bus.a_dest = 3'd2; bus.a_data = 16'h0002;
    bus.b_valid = 1'b1; bus.b_dest = 3'd4; bus.b_data = 16'h0004;
    for (int i = 0; i < 4; i++) begin
      @(posedge clk); #2;
      checkEq("cont_select", bus.select, (i % 2 == 0) ? 1 : 0);
    end
    bus.a_valid = 1'b0; bus.b_valid = 1'b0;
    @(posedge clk); #3 checkEq("cont_count", bus.wr_count, 4);

    // same destination from both: A first, B wins last
    @(posedge clk); #1;
    bus.a_valid = 1'b1; bus.a_dest = 3'd5; bus.a_data = 16'h0055;
    bus.b_valid = 1'b1; bus.b_dest = 3'd5; bus.b_data = 16'h00BB;
    @(posedge clk); #1 bus.a_valid = 1'b0;
    #2 checkEq("same_first_data", bus.writeData, 16'h0055);
    @(posedge clk); #1 bus.b_valid = 1'b0;
    @(posedge clk); #3 checkEq("same_reg5", shadowRegs[5], 16'h00BB);

    // hold for three cycles with A waiting
    @(posedge clk); #1;
    bus.a_valid = 1'b1; bus.a_dest = 3'd1; bus.a_data = 16'h0011; bus.wr_hold = 1'b1;
    repeat (3) begin
      #2;
      checkEq("hold_a_ready", bus.a_ready, 0);
      checkEq("hold_regWrite", bus.regWrite, 0);
      @(posedge clk); #1;
    end
    bus.wr_hold = 1'b0;
    #2 checkEq("hold_exit_a_ready", bus.a_ready, 0);
    @(posedge clk); #3 checkEq("hold_grant", bus.a_ready, 1);
    @(posedge clk); #1 bus.a_valid = 1'b0;

    // reset in the middle of a presented write
    @(posedge clk); #1;
    bus.a_valid = 1'b1; bus.a_dest = 3'd6; bus.a_data = 16'h0666;
    @(posedge clk); #1;
    checkEq("mid_pre_regWrite", bus.regWrite, 1);
    bus.b_valid = 1'b1; bus.b_dest = 3'd7; bus.b_data = 16'h0777;
    reset = 1'b1;
    #1;
    checkEq("mid_regWrite", bus.regWrite, 0);
    checkEq("mid_count", bus.wr_count, 0);
    checkEq("mid_a_ready", bus.a_ready, 0);
    checkEq("mid_b_ready", bus.b_ready, 0);
    @(posedge clk); #1 reset = 1'b0;
    #1 checkEq("mid_a_priority", bus.a_ready, 1);
    @(posedge clk); #1 bus.a_valid = 1'b0; bus.b_valid = 1'b0;
    #1 checkEq("mid_select", bus.select, 1);
    repeat (2) @(posedge clk);

    // 256 back-to-back writes wrap the counter
    doReset();
    bus.a_valid = 1'b1;
    for (int i = 0; i < 256; i++) begin
      bus.a_dest = ADDR_W'(i);
      bus.a_data = DATA_W'(i * 3);
      @(posedge clk); #1;
    end
    checkEq("wrap_255", bus.wr_count, 255);
    bus.a_valid = 1'b0;
    @(posedge clk); #3 checkEq("wrap_zero", bus.wr_count, 0);

    // random mix of requests and holds
    for (int i = 0; i < 80; i++) begin
      @(posedge clk); #1;
      bus.a_valid = 1'($urandom_range(0, 1));
      bus.b_valid = 1'($urandom_range(0, 1));
      bus.a_dest  = ADDR_W'($urandom);
      bus.b_dest  = ADDR_W'($urandom);
      bus.a_data  = DATA_W'($urandom);
      bus.b_data  = DATA_W'($urandom);
      bus.wr_hold = ($urandom_range(0, 4) == 0);
    end
    @(posedge clk); #1;
    bus.a_valid = 1'b0; bus.b_valid = 1'b0; bus.wr_hold = 1'b0;
    repeat (4) @(posedge clk);
    #1 checkEq("drain_queue", expQ.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
